// File: rtl/adder_64b_rr_scheduler_if.sv
// Requester/response bundle for the shared 64-bit adder scheduler.
// master drives beats and consumes responses; slave is the scheduler.
interface adder_64b_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]    i_req_valid;
  logic [NUM_REQ-1:0]    o_req_ready;
  logic [NUM_REQ*64-1:0] i_req_a;
  logic [NUM_REQ*64-1:0] i_req_b;
  logic [NUM_REQ-1:0]    i_req_c_in;
  logic [NUM_REQ-1:0]    i_req_last;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [ID_W-1:0]       o_rsp_id;
  logic [63:0]           o_rsp_sum;
  logic                  o_rsp_c_out;
  logic                  o_rsp_last;
  logic                  o_busy;

  modport master (
    output i_req_valid, i_req_a, i_req_b,
    output i_req_c_in, i_req_last, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_id,
    input  o_rsp_sum, o_rsp_c_out, o_rsp_last, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_a, i_req_b,
    input  i_req_c_in, i_req_last, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_id,
    output o_rsp_sum, o_rsp_c_out, o_rsp_last, o_busy
  );
endinterface

// File: rtl/adder_64b_rr_scheduler.sv
// Round-robin scheduler sharing one 64-bit CLA between requesters,
// with multi-beat carry chaining and a registered response slot.
module adder_cla_64b (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        c_in,
  output logic [63:0] sum,
  output logic        c_out
);
  logic [63:0] gen;
  logic [63:0] prop;
  logic [63:0] c;
  logic [16:0] gc;
  logic        gg;
  logic        gp;

  // 4-bit groups: group generate/propagate feed the group carry chain
  always_comb begin
    gen = a & b;
    prop = a ^ b;
    c = '0;
    gc = '0;
    gc[0] = c_in;
    gg = 1'b0;
    gp = 1'b1;
    for (int j = 0; j < 16; j++) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int i = 0; i < 4; i++) begin
        gg = gen[4*j+i] | (prop[4*j+i] & gg);
        gp = gp & prop[4*j+i];
      end
      gc[j+1] = gg | (gp & gc[j]);
      c[4*j] = gc[j];
      for (int i = 1; i < 4; i++) begin
        c[4*j+i] = gen[4*j+i-1]
                 | (prop[4*j+i-1] & c[4*j+i-1]);
      end
    end
    sum = prop ^ c;
    c_out = gc[16];
  end
endmodule

module adder_64b_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  adder_64b_rr_scheduler_if.slave bus
);
  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] owner;
  logic            chain_carry;

  logic            rsp_valid;
  logic [ID_W-1:0] rsp_id;
  logic [63:0]     rsp_sum;
  logic            rsp_c_out;
  logic            rsp_last;

  logic [ID_W-1:0] gnt;
  logic            found;
  logic            slot_free;
  logic            accept;
  logic [63:0]     op_a;
  logic [63:0]     op_b;
  logic            op_cin;
  logic            beat_last;
  logic [63:0]     add_sum;
  logic            add_cout;

  function automatic logic [ID_W-1:0] nxt(
    input logic [ID_W-1:0] id
  );
    return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
  endfunction

  // Descending scan so the lowest offset from rr_ptr wins
  always_comb begin
    gnt = owner;
    found = 1'b0;
    unique case (state)
      LOCKED: found = bus.i_req_valid[owner];
      default: begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (bus.i_req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
            gnt = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            found = 1'b1;
          end
        end
      end
    endcase
  end

  assign slot_free = !rsp_valid | bus.i_rsp_ready;
  assign accept = found & slot_free & i_rst_n;
  assign bus.o_req_ready =
    accept ? (NUM_REQ'(1) << gnt) : '0;

  assign op_a = bus.i_req_a[int'(gnt)*64 +: 64];
  assign op_b = bus.i_req_b[int'(gnt)*64 +: 64];
  assign beat_last = bus.i_req_last[gnt];
  assign op_cin = (state == LOCKED) ? chain_carry
                                    : bus.i_req_c_in[gnt];

  adder_cla_64b u_add (
    .a     (op_a),
    .b     (op_b),
    .c_in  (op_cin),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      chain_carry <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_sum     <= '0;
      rsp_c_out   <= 1'b0;
      rsp_last    <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt;
      rsp_sum   <= add_sum;
      rsp_c_out <= add_cout;
      rsp_last  <= beat_last;
      if (beat_last) begin
        state  <= IDLE;
        rr_ptr <= nxt(gnt);
      end else begin
        state       <= LOCKED;
        owner       <= gnt;
        chain_carry <= add_cout;
      end
    end else if (bus.i_rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_id    = rsp_id;
  assign bus.o_rsp_sum   = rsp_sum;
  assign bus.o_rsp_c_out = rsp_c_out;
  assign bus.o_rsp_last  = rsp_last;
  assign bus.o_busy      = (state == LOCKED);
endmodule
